serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//   Bit-serial arithmetic sequencer. Latches two WIDTH-bit operands and drives
//   an external single-bit full adder (fulladder: a,b,c -> sum,cout) one bit
//   per cycle, LSB first. It holds the carry between bits and shifts each sum
//   bit into a result register. Start/busy/done handshake toward the issuing
//   logic; sits between the control path and the shared 1-bit adder datapath.
// PARAMETERS
//   WIDTH   4   operand/result width in bits (>=2); bit counter is $clog2(WIDTH+1) wide
// PORTS
//   clk      in   1      rising-edge clock
//   clr      in   1      reset, synchronous, active-high
//   start    in   1      request; sampled on clk, accepted only in IDLE or DONE
//   a        in   WIDTH  operand A, captured on accepted start
//   b        in   WIDTH  operand B, captured on accepted start
//   cin      in   1      carry-in, captured on accepted start
//   fa_a     out  1      to full adder a: current LSB of A shift reg (0 when not RUN)
//   fa_b     out  1      to full adder b: current LSB of B shift reg (0 when not RUN)
//   fa_c     out  1      to full adder c: carry register (0 when not RUN)
//   fa_sum   in   1      from full adder sum (combinational, same cycle)
//   fa_cout  in   1      from full adder cout (combinational, same cycle)
//   busy     out  1      high in RUN
//   done     out  1      one-cycle pulse: result valid
//   sum      out  WIDTH  result, held stable from done until next accepted start
//   cout     out  1      final carry, held like sum
//   eq       out  1      (SERIAL_CMP_EN only) a==b, held like sum
// BEHAVIOUR
//   - Reset: on clk edge with clr=1 -> state IDLE; busy=0, done=0, sum=0, cout=0,
//     eq=0, carry=0, count=0, shift regs=0. clr has priority over all inputs,
//     including mid-RUN: the operation is aborted, and no done pulse is produced.
//   - FSM states: IDLE, RUN, DONE.
//     IDLE: start=1 -> load A<=a, B<=b, carry<=cin, count<=0 -> RUN.
//     RUN : each cycle sum_sh<={fa_sum,sum_sh[WIDTH-1:1]}, carry<=fa_cout,
//           A,B shift right by 1, count++; when count==WIDTH-1 -> DONE.
//           start is ignored in RUN and is not queued.
//     DONE: done=1 for this cycle only; sum/cout registered from final bit.
//           start=1 -> reload as in IDLE -> RUN (back-to-back, no idle cycle);
//           otherwise -> IDLE.
//   - Latency: start accepted at edge k -> busy high in cycles k+1..k+WIDTH,
//     done high in cycle k+WIDTH+1. The full adder is used exactly WIDTH cycles.
//   - Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). The final carry
//     out of the MSB is cout. There is no overflow flag.
//   - Outputs are all registered, except fa_*, which are combinational from
//     registers. fa_* are forced to 0 outside RUN.
//   - sum/cout update only on the RUN->DONE transition. They are never
//     partially updated while busy.
// CONFIGURATION
//   SERIAL_CMP_EN defined: adds port eq. An eq_acc register is set to 1 on
//     load; in RUN, eq_acc<=eq_acc & ~(fa_a^fa_b). eq<=eq_acc result on the
//     RUN->DONE edge, held like sum, and reset to 0.
//   SERIAL_CMP_EN undefined: eq port and eq_acc do not exist. All other
//     behaviour is identical.
// TESTING
//   1. WIDTH=4, a=5, b=3, cin=0, start pulse -> busy 4 cycles; done in cycle
//      k+5; sum=8, cout=0.
//   2. a=15, b=1, cin=0 -> sum=0, cout=1. Also a=0, b=0, cin=1 -> sum=1, cout=0.
//   3. start held high through RUN -> exactly one op; second op starts from
//      DONE without an IDLE cycle; sum of 2nd = new operands.
//   4. clr=1 in 2nd RUN cycle -> next cycle busy=0, done never pulses, sum=0,
//      cout=0, fa_*=0.
//   5. SERIAL_CMP_EN: a=b=9 -> eq=1; a=9, b=8 -> eq=0. Without macro, the
//      build has no eq port.
//   6. Random a/b/cin over 200 ops with the fulladder model: {cout,sum} ==
//      a+b+cin; fa_* are 0 whenever busy=0.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: feeds an external 1-bit full adder LSB first and
// collects {cout,sum} = a + b + cin. Optional equality compare under SERIAL_CMP_EN.
module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_CMP_EN
    ,
    output logic             eq
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] a_reg, b_reg, sh_reg, sum_reg;
    logic [CW-1:0]    count_reg;
    logic             carry_reg, cout_reg;
    logic             running, last_bit, load;
    logic [WIDTH-1:0] sh_next;

    assign running  = (state_reg == RUN);
    assign last_bit = running && (count_reg == CW'(WIDTH - 1));
    // start is honoured only outside RUN; requests during RUN are dropped
    assign load     = start && !running;
    assign sh_next  = {fa_sum, sh_reg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sh_reg    <= '0;
            sum_reg   <= '0;
            count_reg <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
        end else if (running) begin
            sh_reg    <= sh_next;
            carry_reg <= fa_cout;
            a_reg     <= a_reg >> 1;
            b_reg     <= b_reg >> 1;
            count_reg <= count_reg + CW'(1);
            // result registers change only on the final bit, never mid-operation
            if (last_bit) begin
                sum_reg  <= sh_next;
                cout_reg <= fa_cout;
            end
        end else if (load) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            count_reg <= '0;
        end
    end

`ifdef SERIAL_CMP_EN
    logic eq_acc_reg, eq_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            eq_acc_reg <= 1'b0;
            eq_reg     <= 1'b0;
        end else if (running) begin
            eq_acc_reg <= eq_acc_reg & ~(fa_a ^ fa_b);
            if (last_bit) begin
                eq_reg <= eq_acc_reg & ~(fa_a ^ fa_b);
            end
        end else if (load) begin
            eq_acc_reg <= 1'b1;
        end
    end

    assign eq = eq_reg;
`endif

    assign fa_a = running & a_reg[0];
    assign fa_b = running & b_reg[0];
    assign fa_c = running & carry_reg;
    assign busy = running;
    assign done = (state_reg == DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl with a behavioural full adder; define
// SERIAL_CMP_EN to also check the eq output.
module tb_serial_add_ctrl;

    localparam int WIDTH = 4;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             co;
        logic             e;
    } exp_t;

    logic             clk = 1'b0;
    logic             clr, start, cin;
    logic [WIDTH-1:0] a, b;
    logic             fa_a, fa_b, fa_c, fa_sum, fa_cout;
    logic             busy, done, cout;
    logic [WIDTH-1:0] sum;
    logic             eq;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic tb_end = 1'b0;

    always #5 clk = ~clk;

    // external single-bit full adder
    assign fa_sum  = fa_a ^ fa_b ^ fa_c;
    assign fa_cout = (fa_a & fa_b) | (fa_c & (fa_a ^ fa_b));

`ifndef SERIAL_CMP_EN
    assign eq = 1'b0;
`endif

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .clr    (clr),
        .start  (start),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .fa_a   (fa_a),
        .fa_b   (fa_b),
        .fa_c   (fa_c),
        .fa_sum (fa_sum),
        .fa_cout(fa_cout),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout)
`ifdef SERIAL_CMP_EN
        ,
        .eq     (eq)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic c);
        int   full;
        exp_t r;
        full = int'(x) + int'(y) + int'(c);
        r.s  = WIDTH'(full % (1 << WIDTH));
        r.co = ((full >> WIDTH) & 1) != 0;
        r.e  = (x == y);
        return r;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic [WIDTH:0] hold;
    int   run, idle_w, cyc;
    logic rst_chk, busy_chk, busy_exp;
    exp_t got_e, want;

    initial begin
        hold = '0; run = 0; idle_w = 0; cyc = 0;
        rst_chk = 1'b0; busy_chk = 1'b0; busy_exp = 1'b0;
    end

    always @(negedge clk) begin
        cyc++;
        if (rst_chk) begin
            chk("reset_busy", 32'(busy), 0);
            chk("reset_done", 32'(done), 0);
            chk("reset_sum", 32'({cout, sum}), 0);
            chk("reset_fa", 32'({fa_a, fa_b, fa_c}), 0);
`ifdef SERIAL_CMP_EN
            chk("reset_eq", 32'(eq), 0);
`endif
            rst_chk = 1'b0;
        end
        if (clr) begin
            rst_chk  = 1'b1;
            hold     = '0;
            run      = 0;
            busy_chk = 1'b0;
            idle_w   = 0;
        end else begin
            if (busy_chk) begin
                chk("after_done_busy", 32'(busy), 32'(busy_exp));
                busy_chk = 1'b0;
            end
            if (!busy) chk("fa_idle_zero", 32'({fa_a, fa_b, fa_c}), 0);
            if (busy) begin
                run++;
                chk("held_while_busy", 32'({cout, sum}), 32'(hold));
                if (run == WIDTH + 1) chk("busy_too_long", 32'(run), WIDTH);
            end
            if (done) begin
                chk("busy_cycles", 32'(run), WIDTH);
                run = 0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    want = exp_q.pop_front();
                    got_e.s = sum; got_e.co = cout; got_e.e = eq;
                    chk("sum", 32'(sum), 32'(want.s));
                    chk("cout", 32'(cout), 32'(want.co));
`ifdef SERIAL_CMP_EN
                    chk("eq", 32'(eq), 32'(want.e));
`endif
                    $display("op %0d: sum=%0d cout=%0d eq=%0d", total, sum, cout, eq);
                    hold = {want.co, want.s};
                end
                busy_exp = start;
                busy_chk = 1'b1;
            end else if (!busy) begin
                run = 0;
            end
            if (exp_q.size() != 0 && !busy && !done) begin
                idle_w++;
                if (idle_w == 8) chk("op_not_started", 0, 1);
            end else begin
                idle_w = 0;
            end
        end
        if (tb_end || cyc > 20000) begin
            if (cyc > 20000) chk("global_timeout", 32'(cyc), 20000);
            chk("queue_drained", 32'(exp_q.size()), 0);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ready();
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic c, input bit push);
        a = x; b = y; cin = c; start = 1'b1;
        if (push) exp_q.push_back(model(x, y, c));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1 clr = 1'b0;
        @(posedge clk); #1;

        issue(4'd5, 4'd3, 1'b0, 1);
        wait_ready();
        issue(4'd15, 4'd1, 1'b0, 1);
        wait_ready();
        issue(4'd0, 4'd0, 1'b1, 1);
        wait_ready();
        issue(4'd9, 4'd9, 1'b0, 1);
        wait_ready();
        issue(4'd9, 4'd8, 1'b0, 1);
        wait_ready();

        // start held high across a whole operation: one op, then a direct reload from DONE
        a = 4'd10; b = 4'd7; cin = 1'b1; start = 1'b1;
        exp_q.push_back(model(4'd10, 4'd7, 1'b1));
        @(posedge clk); #1;
        a = 4'd3; b = 4'd12; cin = 1'b0;
        exp_q.push_back(model(4'd3, 4'd12, 1'b0));
        repeat (WIDTH) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        wait_ready();
        @(posedge clk); #1;

        // abort in the second RUN cycle: no result expected
        issue(4'd6, 4'd6, 1'b1, 0);
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        repeat (WIDTH + 3) begin
            @(posedge clk); #1;
        end

        for (int n = 0; n < 200; n++) begin
            wait_ready();
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1);
        end
        wait_ready();
        repeat (4) begin
            @(posedge clk); #1;
        end
        tb_end = 1'b1;
    end

endmodule
